// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch: program counter and instruction fetch unit for the three-phase
// (Fetch/Read/Execute) processor core.
//
// This file also carries the `opcodes` package. It defines the PC command
// encoding that the control unit and this block share.
//
// Optional feature macro: PC_FETCH_JMP_REL_EN
//   defined   -> PcJmp is PC-relative (Pc + sign-extended JmpTarget, mod 2^PC_WIDTH)
//   undefined -> PcJmp uses JmpTarget as an absolute address
//
// Ports:
//   Clock       in   system clock, rising edge
//   nReset      in   asynchronous active-low reset
//   PcSel       in   PC command (PcWait/PcInc/PcJmp), sampled only in Execute
//   JmpTarget   in   jump operand (absolute address or signed offset)
//   IAddr       out  instruction ROM address (always equals Pc)
//   IData       in   synchronous ROM data, valid one cycle after IAddr
//   Instr       out  instruction register
//   OpCode      out  Instr[15:12]
//   Imm         out  Instr[7:0]
//   Pc          out  current program counter
//   Phase       out  0 = Fetch, 1 = Read, 2 = Execute
//   InstrValid  out  Instr holds a fetched word
//   Fault       out  sticky out-of-range jump flag
//   InstrCount  out  saturating retired-instruction counter
// ---------------------------------------------------------------------------

package opcodes;

    typedef enum logic [1:0] {
        PcWait = 2'd0,
        PcInc  = 2'd1,
        PcJmp  = 2'd2
    } PcSel_t;

    typedef logic [3:0] opcodes_t;

endpackage

module pc_fetch #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned PROG_DEPTH  = 256,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic [1:0]             PcSel,
    input  logic [PC_WIDTH-1:0]    JmpTarget,
    output logic [PC_WIDTH-1:0]    IAddr,
    input  logic [INSTR_WIDTH-1:0] IData,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [3:0]             OpCode,
    output logic [7:0]             Imm,
    output logic [PC_WIDTH-1:0]    Pc,
    output logic [1:0]             Phase,
    output logic                   InstrValid,
    output logic                   Fault,
    output logic [15:0]            InstrCount
);

    localparam logic [1:0] PH_FETCH = 2'd0;
    localparam logic [1:0] PH_READ  = 2'd1;
    localparam logic [1:0] PH_EXEC  = 2'd2;

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_DEPTH - 1);
    // One bit wider than the PC so a depth of exactly 2^PC_WIDTH is representable.
    localparam logic [PC_WIDTH:0]   DEPTH_X = (PC_WIDTH + 1)'(PROG_DEPTH);

    logic [1:0]             phase_q;
    logic [1:0]             phase_next;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    jmp_dest;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q;
    logic                   fault_q;
    logic                   fault_set;
    logic                   retire;
    logic [15:0]            count_q;

    // Jump destination before the range check.
`ifdef PC_FETCH_JMP_REL_EN
    // JmpTarget is already PC_WIDTH wide, so its sign extension is itself.
    // Adding it modulo 2^PC_WIDTH gives the two's-complement offset.
    always_comb jmp_dest = pc_q + JmpTarget;
`else
    always_comb jmp_dest = JmpTarget;
`endif

    always_comb begin
        case (phase_q)
            PH_FETCH: phase_next = PH_READ;
            PH_READ:  phase_next = PH_EXEC;
            default:  phase_next = PH_FETCH;  // Execute and the unreachable code 3
        endcase
    end

    always_comb begin
        pc_next   = pc_q;
        fault_set = 1'b0;
        retire    = 1'b0;
        if (phase_q == PH_EXEC) begin
            case (PcSel)
                opcodes::PcInc: begin
                    retire  = 1'b1;
                    pc_next = (pc_q == LAST_PC) ? '0 : pc_q + PC_WIDTH'(1);
                end
                opcodes::PcJmp: begin
                    retire = 1'b1;
                    if ({1'b0, jmp_dest} >= DEPTH_X) begin
                        pc_next   = '0;
                        fault_set = 1'b1;
                    end else begin
                        pc_next = jmp_dest;
                    end
                end
                default: ;  // PcWait and the illegal encoding hold the PC
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            phase_q <= PH_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            phase_q <= phase_next;
            pc_q    <= pc_next;
            if (phase_q == PH_READ) begin
                instr_q <= IData;
                valid_q <= 1'b1;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (retire && (count_q != '1)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign IAddr      = pc_q;
    assign Pc         = pc_q;
    assign Phase      = phase_q;
    assign Instr      = instr_q;
    assign OpCode     = instr_q[INSTR_WIDTH-1 -: 4];
    assign Imm        = instr_q[7:0];
    assign InstrValid = valid_q;
    assign Fault      = fault_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch: self-checking bench for pc_fetch.
//
// Two instances share one stimulus stream. Instance 0 has PROG_DEPTH=256 and
// instance 1 has PROG_DEPTH=64. Each instance has its own synchronous ROM
// model and its own instruction-level reference model.
// ---------------------------------------------------------------------------

module tb_pc_fetch;

    logic              clk;
    logic              rst_n;
    logic [1:0]        pcsel;
    logic [7:0]        jmp;
    logic [1:0][7:0]   iaddr;
    logic [1:0][15:0]  idata;
    logic [1:0][15:0]  instr;
    logic [1:0][3:0]   opcode;
    logic [1:0][7:0]   imm;
    logic [1:0][7:0]   pc;
    logic [1:0][1:0]   phase;
    logic [1:0]        valid;
    logic [1:0]        fault;
    logic [1:0][15:0]  count;

    logic [15:0] rom [256];

    int total = 0;
    int bad   = 0;

    int          depth [2] = '{256, 64};
    int          m_pc    [2];
    int          m_cnt   [2];
    logic        m_fault [2];
    logic        m_valid [2];
    logic [15:0] m_instr [2];

    pc_fetch #(.PC_WIDTH(8), .PROG_DEPTH(256), .INSTR_WIDTH(16)) dut0 (
        .Clock(clk), .nReset(rst_n), .PcSel(pcsel), .JmpTarget(jmp),
        .IAddr(iaddr[0]), .IData(idata[0]), .Instr(instr[0]), .OpCode(opcode[0]),
        .Imm(imm[0]), .Pc(pc[0]), .Phase(phase[0]), .InstrValid(valid[0]),
        .Fault(fault[0]), .InstrCount(count[0])
    );

    pc_fetch #(.PC_WIDTH(8), .PROG_DEPTH(64), .INSTR_WIDTH(16)) dut1 (
        .Clock(clk), .nReset(rst_n), .PcSel(pcsel), .JmpTarget(jmp),
        .IAddr(iaddr[1]), .IData(idata[1]), .Instr(instr[1]), .OpCode(opcode[1]),
        .Imm(imm[1]), .Pc(pc[1]), .Phase(phase[1]), .InstrValid(valid[1]),
        .Fault(fault[1]), .InstrCount(count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs: data appears one edge after the address.
    always @(posedge clk) begin
        idata[0] <= rom[iaddr[0]];
        idata[1] <= rom[iaddr[1]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = 0;
            m_cnt[i]   = 0;
            m_fault[i] = 1'b0;
            m_valid[i] = 1'b0;
            m_instr[i] = 16'h0000;
        end
    endtask

    task automatic model_exec(input logic [1:0] sel, input logic [7:0] tgt);
        int t;
        for (int i = 0; i < 2; i++) begin
            if (sel == opcodes::PcInc) begin
                m_pc[i] = (m_pc[i] + 1) % depth[i];
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end else if (sel == opcodes::PcJmp) begin
`ifdef PC_FETCH_JMP_REL_EN
                t = (m_pc[i] + int'(tgt)) % 256;
`else
                t = int'(tgt);
`endif
                if (t >= depth[i]) begin
                    m_pc[i]    = 0;
                    m_fault[i] = 1'b1;
                end else begin
                    m_pc[i] = t;
                end
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_phase%0d", i), 32'(phase[i]), 32'd0);
            check($sformatf("rst_pc%0d", i),    32'(pc[i]),    32'd0);
            check($sformatf("rst_iaddr%0d", i), 32'(iaddr[i]), 32'd0);
            check($sformatf("rst_instr%0d", i), 32'(instr[i]), 32'd0);
            check($sformatf("rst_opcode%0d", i), 32'(opcode[i]), 32'd0);
            check($sformatf("rst_imm%0d", i),   32'(imm[i]),   32'd0);
            check($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'd0);
            check($sformatf("rst_fault%0d", i), 32'(fault[i]), 32'd0);
            check($sformatf("rst_count%0d", i), 32'(count[i]), 32'd0);
        end
    endtask

    task automatic check_fetch();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("f_phase%0d", i), 32'(phase[i]), 32'd0);
            check($sformatf("f_pc%0d", i),    32'(pc[i]),    32'(m_pc[i]));
            check($sformatf("f_iaddr%0d", i), 32'(iaddr[i]), 32'(m_pc[i]));
            check($sformatf("f_fault%0d", i), 32'(fault[i]), 32'(m_fault[i]));
            check($sformatf("f_count%0d", i), 32'(count[i]), 32'(m_cnt[i]));
            check($sformatf("f_valid%0d", i), 32'(valid[i]), 32'(m_valid[i]));
            check($sformatf("f_instr%0d", i), 32'(instr[i]), 32'(m_instr[i]));
        end
    endtask

    // One full instruction period. Entered and left just after a falling edge in Fetch.
    // Random junk is driven on PcSel/JmpTarget during Fetch and Read, where it must be ignored.
    task automatic run_instr(input logic [1:0] sel, input logic [7:0] tgt);
        logic [15:0] w;
        check_fetch();
        pcsel = 2'($urandom);
        jmp   = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("r_phase%0d", i), 32'(phase[i]), 32'd1);
            check($sformatf("r_pc%0d", i),    32'(pc[i]),    32'(m_pc[i]));
            check($sformatf("r_instr%0d", i), 32'(instr[i]), 32'(m_instr[i]));
        end
        pcsel = 2'($urandom);
        jmp   = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            w = rom[m_pc[i]];
            m_instr[i] = w;
            m_valid[i] = 1'b1;
            check($sformatf("x_phase%0d", i),  32'(phase[i]),  32'd2);
            check($sformatf("x_instr%0d", i),  32'(instr[i]),  32'(w));
            check($sformatf("x_opcode%0d", i), 32'(opcode[i]), 32'(w[15:12]));
            check($sformatf("x_imm%0d", i),    32'(imm[i]),    32'(w[7:0]));
            check($sformatf("x_valid%0d", i),  32'(valid[i]),  32'd1);
        end
        pcsel = sel;
        jmp   = tgt;
        @(posedge clk);
        model_exec(sel, tgt);
        @(negedge clk);
    endtask

    // Jump instance 0 to an absolute address, whichever jump mode is built.
    task automatic goto_addr(input logic [7:0] addr);
        logic [7:0] t;
`ifdef PC_FETCH_JMP_REL_EN
        t = addr - 8'(m_pc[0]);
`else
        t = addr;
`endif
        run_instr(opcodes::PcJmp, t);
    endtask

    initial begin
        logic [15:0] held;
        for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
        rom[0] = 16'hA123;
        pcsel = 2'd0;
        jmp   = 8'd0;
        rst_n = 1'b0;
        model_reset();

        // Reset state, then release on a falling edge: that cycle is Fetch (cycle 0).
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // First instruction: ROM[0] = A123 shows up in the Execute of cycle 2.
        run_instr(opcodes::PcInc, 8'h00);
        check("first_opcode", 32'(m_instr[0][15:12]), 32'hA);
        check("first_pc", 32'(pc[0]), 32'd1);

        // Incrementing across the top of a 256-word program wraps to 0.
        goto_addr(8'hFE);
        check("pc_fe", 32'(pc[0]), 32'hFE);
        run_instr(opcodes::PcInc, 8'h00);
        check("pc_ff", 32'(pc[0]), 32'hFF);
        run_instr(opcodes::PcInc, 8'h00);
        check("pc_wrap", 32'(pc[0]), 32'h00);
        check("wrap_fault", 32'(fault[0]), 32'd0);

        // PcWait holds Pc, Instr and InstrCount.
        goto_addr(8'h05);
        run_instr(opcodes::PcWait, 8'h00);
        held = instr[0];
        for (int k = 0; k < 3; k++) run_instr(opcodes::PcWait, 8'h00);
        check("wait_pc", 32'(pc[0]), 32'd5);
        check("wait_instr", 32'(instr[0]), 32'(held));
        run_instr(opcodes::PcWait, 8'h00);

        // Jump to 0x40: in range for depth 256, out of range (sticky fault) for depth 64.
        goto_addr(8'h40);
        check("jmp40_iaddr", 32'(iaddr[0]), 32'h40);
        check("jmp40_d64_fault", 32'(fault[1]), 32'd1);
        for (int k = 0; k < 3; k++) run_instr(opcodes::PcInc, 8'h00);
        check("fault_sticky", 32'(fault[1]), 32'd1);

        // Asynchronous reset in the middle of Read after a jump to 0x30.
        goto_addr(8'h30);
        check_fetch();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_iaddr", 32'(iaddr[0]), 32'd0);
        run_instr(opcodes::PcInc, 8'h00);

`ifdef PC_FETCH_JMP_REL_EN
        // Relative jumps: 0x10 - 4 = 0x0C; 0x02 - 4 wraps to 0xFE.
        goto_addr(8'h10);
        run_instr(opcodes::PcJmp, 8'hFC);
        check("rel_back", 32'(pc[0]), 32'h0C);
        check("rel_back_d64", 32'(pc[1]), 32'h0C);
        goto_addr(8'h02);
        run_instr(opcodes::PcJmp, 8'hFC);
        check("rel_wrap", 32'(pc[0]), 32'hFE);
        check("rel_wrap_d64_pc", 32'(pc[1]), 32'd0);
        check("rel_wrap_d64_fault", 32'(fault[1]), 32'd1);
`endif

        // Random command stream, including the illegal encoding and junk in Fetch/Read.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] s;
            logic [7:0] t;
            s = 2'($urandom_range(0, 3));
            t = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
            run_instr(s, t);
        end
        check_fetch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter and instruction fetch unit for the three-phase processor core. It consumes the `PcSel` command that the control unit issues in its Execute phase and holds the program counter. It drives the instruction ROM address, captures the returned word into an instruction register, and presents `OpCode` and the immediate field back to the control unit and datapath. It runs its own Fetch/Read/Execute phase sequencer, which is reset-locked to the control unit's sequencer.

## Interface
- `PC_WIDTH`, 8, program counter and ROM address width.
- `PROG_DEPTH`, 256, number of valid instruction words; the last valid address is `PROG_DEPTH-1`. Must be ≤ 2^`PC_WIDTH`.
- `INSTR_WIDTH`, 16, instruction word width: `[15:12]` opcode, `[11:8]` register fields, `[7:0]` immediate.

Ports:
- `Clock` in 1: system clock, rising-edge active.
- `nReset` in 1: reset, asynchronous, active-low.
- `PcSel` in `opcodes::PcSel_t`: PC command (`PcWait`, `PcInc`, `PcJmp`); sampled only in Execute.
- `JmpTarget` in `PC_WIDTH`: jump operand from the immediate/ALU path.
- `IAddr` out `PC_WIDTH`: ROM address; always equals `Pc`.
- `IData` in `INSTR_WIDTH`: synchronous ROM data, valid one cycle after `IAddr`.
- `Instr` out `INSTR_WIDTH`: instruction register.
- `OpCode` out `opcodes::opcodes_t`: `Instr[15:12]`.
- `Imm` out 8: `Instr[7:0]`.
- `Pc` out `PC_WIDTH`: current program counter.
- `Phase` out 2: 0 = Fetch, 1 = Read, 2 = Execute.
- `InstrValid` out 1: `Instr` holds a fetched word.
- `Fault` out 1: sticky out-of-range jump flag.
- `InstrCount` out 16: retired-instruction counter.

## Operation
- Reset values: `Pc`=0, `Instr`=0 (decodes as NOOP), `Phase`=Fetch, `InstrValid`=0, `Fault`=0, `InstrCount`=0.
- Phase sequencer: Fetch → Read → Execute → Fetch, unconditionally. Encoding 3 is unreachable; if entered, the sequencer returns to Fetch on the next edge.
- Fetch: `IAddr`=`Pc`; the ROM registers the word on the Fetch→Read edge.
- Read: on the Read→Execute edge, `Instr` ← `IData` and `InstrValid` ← 1.
- Execute: `PcSel` is sampled on the Execute→Fetch edge.
  - `PcInc`: `Pc` ← `Pc`+1. If `Pc` = `PROG_DEPTH-1`, `Pc` wraps to 0.
  - `PcJmp`: `Pc` ← target. If the target ≥ `PROG_DEPTH`, `Pc` ← 0 and `Fault` ← 1.
  - `PcWait`: `Pc` holds. The same word is re-fetched and re-captured, so `Instr` is unchanged.
  - Any illegal encoding: treated as `PcWait`.
- `PcSel` and `JmpTarget` are ignored in Fetch and Read.
- `InstrCount` increments on each Execute→Fetch edge where `PcSel` is `PcInc` or `PcJmp`. It saturates at 16'hFFFF.
- `Fault` clears only on reset.
- Reset mid-phase: all state returns to reset values immediately (asynchronous). The first fetch after release is from address 0.

## Timing
- Latency from `nReset` release to the first valid `Instr`: 2 rising edges. `Instr` is valid throughout the first Execute, which is cycle 2.
- One instruction per 3 cycles. `Pc` updates at the end of Execute and is visible in the next Fetch.
- `IAddr`, `OpCode` and `Imm` are glitch-free register outputs. `OpCode` is stable across the full Execute phase.
- A jump takes effect on the very next Fetch; there is no delay slot.

## Configuration
- `PC_FETCH_JMP_REL_EN` defined:
  - `PcJmp` is relative: target = `Pc` + sign-extended `JmpTarget`, computed modulo 2^`PC_WIDTH`.
  - If the result is ≥ `PROG_DEPTH`, `Pc` ← 0 and `Fault` is set.
- Not defined:
  - The target is `JmpTarget`, used as an absolute address.

## Test plan
- Reset release with ROM[0]=16'hA123 → cycle 2: `Phase`=2, `OpCode`=4'hA, `Imm`=8'h23, `InstrValid`=1. `Pc` becomes 1 at cycle 3.
- `PcInc` every Execute with `PROG_DEPTH`=256, starting at `Pc`=8'hFE → `Pc` goes 8'hFF then 8'h00. `InstrCount` increments by 2 and `Fault` stays 0.
- `PcWait` for 4 instruction periods at `Pc`=5 → `Pc` stays 5, `Instr` is unchanged, and `InstrCount` is unchanged.
- Absolute `PcJmp` with `JmpTarget`=8'h40 → next Fetch `IAddr`=8'h40. With `PROG_DEPTH`=64, the same jump gives `Pc`=0 and `Fault`=1, and `Fault` stays set through later `PcInc`s.
- With `PC_FETCH_JMP_REL_EN` defined, `Pc`=8'h10 and `JmpTarget`=8'hFC → `Pc`=8'h0C. With `Pc`=8'h02 and `JmpTarget`=8'hFC, the target wraps to 8'hFE, which is out of range for `PROG_DEPTH`=64, so `Pc`=0 and `Fault`=1.
- `nReset` asserted mid-Read after a jump to 8'h30 → all outputs return to reset values at once. After release, `IAddr`=0 and the first Execute occurs 2 edges later.
